// File: rtl/avl_bus_pkg.sv
// rtl/avl_bus_pkg.sv - shared types and constants for the Avalon-MM master bridge
package avl_bus_pkg;

  localparam int AVL_AW = 32;
  localparam int AVL_DW = 32;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    RESP  = 2'd3
  } bridge_state_t;

endpackage

// File: rtl/avl_wait_timer.sv
// rtl/avl_wait_timer.sv - stall counter with clear/enable and terminal-count flag
module avl_wait_timer #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Terminal count fires on the Nth enabled cycle, so the abort lands on that edge.
  assign o_tc = i_en && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/avl_master_bridge.sv
// rtl/avl_master_bridge.sv - merges CPU fetch and data ports onto one Avalon-MM master
module avl_master_bridge
  import avl_bus_pkg::*;
#(
  parameter int DATA_PRIORITY  = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        busy,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  bridge_state_t r_state;
  logic          w_in_bus;
  logic          w_timeout;
  logic          w_take_d;
  logic          w_unused_bits;

  assign w_in_bus      = (r_state == BUS_I) || (r_state == BUS_D);
  assign w_take_d      = d_req && ((DATA_PRIORITY != 0) || !i_req);
  assign w_unused_bits = ^{i_addr[1:0], d_addr[1:0]};

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timer
      avl_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_timer (
        .clk   (clk),
        .reset (reset),
        .i_clr (!w_in_bus),
        .i_en  (w_in_bus && waitrequest),
        .o_tc  (w_timeout)
      );
    end else begin : g_no_timer
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      read       <= 1'b0;
      write      <= 1'b0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take_d) begin
            address    <= {d_addr[31:2], 2'b00};
            byteenable <= d_be;
            writedata  <= d_wdata;
            read       <= !d_we;
            write      <= d_we;
            busy       <= 1'b1;
            r_state    <= BUS_D;
          end else if (i_req) begin
            address    <= {i_addr[31:2], 2'b00};
            byteenable <= BE_WORD;
            read       <= 1'b1;
            write      <= 1'b0;
            busy       <= 1'b1;
            r_state    <= BUS_I;
          end
        end
        BUS_I, BUS_D: begin
          // Done pulses are set on the exit edge so they are visible during RESP.
          if (!waitrequest) begin
            if (r_state == BUS_I) begin
              i_rdata <= readdata;
              i_done  <= 1'b1;
            end else begin
              if (read) begin
                d_rdata <= readdata;
              end
              d_done <= 1'b1;
            end
            read    <= 1'b0;
            write   <= 1'b0;
            r_state <= RESP;
          end else if (w_timeout) begin
            i_done  <= (r_state == BUS_I);
            d_done  <= (r_state == BUS_D);
            err     <= 1'b1;
            read    <= 1'b0;
            write   <= 1'b0;
            r_state <= RESP;
          end
        end
        RESP: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
